// File: rtl/serial_nibble_adder_pkg.sv
// ---------------------------------------------------------------------------
// sna_pkg
//   Shared definitions for the nibble-serial adder:
//     NIBBLE_W     width of one add step (the 4-bit ripple datapath)
//     sna_state_e  FSM state encoding (IDLE -> ADD -> DONE -> IDLE)
//     cnt_width()  width of the nibble counter, never below one bit
// ---------------------------------------------------------------------------
package sna_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } sna_state_e;

  // A single-nibble adder still needs a 1-bit counter so the state
  // vector stays a legal, non-zero width.
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/serial_nibble_adder_if.sv
// ---------------------------------------------------------------------------
// serial_nibble_adder_if
//   Operand and result channels of the nibble-serial adder.
//
//   Handshake rule for both channels: a transfer happens on a rising clock
//   edge where valid and ready are both high. A source that raises valid
//   keeps valid and its data stable until that edge; ready may change
//   freely and never depends combinationally on valid.
//
//   Signals
//     in_valid   source -> adder   operands present
//     in_ready   adder  -> source  adder can accept operands
//     in_a/in_b  source -> adder   WIDTH-bit operands
//     out_valid  adder  -> sink    result present
//     out_ready  sink   -> adder   sink takes result
//     out_sum    adder  -> sink    (A+B) mod 2^WIDTH
//     out_cout   adder  -> sink    carry out of bit WIDTH-1
//
//   Modports
//     master  the operand source / result consumer side
//     slave   the adder itself
// ---------------------------------------------------------------------------
interface serial_nibble_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_cout
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_cout
  );

endinterface

// File: rtl/serial_nibble_adder_nibble_add_cin.sv
// ---------------------------------------------------------------------------
// nibble_add_cin
//   Purely combinational 4-bit adder with carry-in, built as a chain of
//   full-adder cells (bit 0 first). Used once per clock by the serial adder
//   to add the current operand nibbles plus the carry held from the
//   previous nibble.
//
//   Ports
//     a_i, b_i  in   NIBBLE_W  operand nibbles
//     cin_i     in   1         carry into bit 0
//     s_o       out  NIBBLE_W  sum nibble
//     cout_o    out  1         carry out of bit NIBBLE_W-1
// ---------------------------------------------------------------------------
module nibble_add_cin
  import sna_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                cout_o
);

  // The ripple carry lives in a procedural variable so each loop iteration
  // is one full-adder cell feeding the next.
  always_comb begin
    logic c;
    logic p;
    s_o = '0;
    c   = cin_i;
    for (int i = 0; i < NIBBLE_W; i++) begin
      p      = a_i[i] ^ b_i[i];
      s_o[i] = p ^ c;
      c      = (a_i[i] & b_i[i]) | (c & p);
    end
    cout_o = c;
  end

endmodule

// File: rtl/serial_nibble_adder.sv
// ---------------------------------------------------------------------------
// serial_nibble_adder
//   Nibble-serial adder. Accepts two WIDTH-bit operands, adds them one
//   nibble per clock (least significant first) through a single 4-bit
//   adder, carrying between cycles, and then presents the WIDTH-bit sum and
//   carry-out until the consumer takes them.
//
//   Timing (WIDTH=16): operands accepted in cycle 0, four ADD cycles, result
//   valid from cycle 5. One operation every NIBBLES+2 cycles at best; no
//   operands are accepted in the cycle a result is taken.
//
//   out_sum/out_cout are registers: they hold the last result through IDLE
//   and ADD and only change on the ADD -> DONE transition (or reset).
//   in_ready and out_valid are pure decodes of the state register, so there
//   is no combinational path from any input to any output.
//
//   Ports
//     clk          in   1        clock, all state on rising edge
//     rst          in   1        synchronous active-high reset
//     bus          slave         operand/result channels (see interface)
//     dbg_state_o  out  2        current FSM state, for observation
//
//   Parameters
//     WIDTH  operand/sum width; multiple of 4, at least 4
// ---------------------------------------------------------------------------
module serial_nibble_adder
  import sna_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  serial_nibble_adder_if.slave       bus,
  output sna_state_e                 dbg_state_o
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  // Elaboration-time guard on the operand width.
  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
    $error("serial_nibble_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  sna_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;

  // Decoded handshake outputs
  logic in_ready_c;
  logic out_valid_c;

  // -------------------------------------------------------------------------
  // Per-nibble datapath: current low nibbles plus held carry
  // -------------------------------------------------------------------------
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_c;
  logic [WIDTH-1:0]    acc_shift;

  nibble_add_cin u_nibble_add (
    .a_i    (a_sh_q[NIBBLE_W-1:0]),
    .b_i    (b_sh_q[NIBBLE_W-1:0]),
    .cin_i  (carry_q),
    .s_o    (nib_s),
    .cout_o (nib_c)
  );

  // New nibble enters at the top of the accumulator and earlier nibbles
  // move down; after NIBBLES steps the first nibble sits at bit 0. Written
  // as a shift of the concatenation so the same expression also covers
  // WIDTH=4, where the accumulator is just the new nibble.
  assign acc_shift = WIDTH'({nib_s, acc_q} >> NIBBLE_W);

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          a_sh_d  = bus.in_a;
          b_sh_d  = bus.in_b;
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        carry_d = nib_c;
        acc_d   = acc_shift;
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last nibble: publish the assembled sum and the final carry.
        if (cnt_q == LAST_CNT) begin
          sum_d   = acc_shift;
          cout_d  = nib_c;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_serial_nibble_adder.sv
module tb_serial_nibble_adder;
  import sna_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  serial_nibble_adder_if #(.WIDTH(16)) b16 ();
  serial_nibble_adder_if #(.WIDTH(4))  b4  ();
  serial_nibble_adder_if #(.WIDTH(32)) b32 ();

  sna_state_e st16, st4, st32;

  serial_nibble_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave), .dbg_state_o(st16));
  serial_nibble_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4.slave),  .dbg_state_o(st4));
  serial_nibble_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave), .dbg_state_o(st32));

  // Scoreboards for the random runs: {cout, sum}
  logic [16:0] exp16_q[$];
  logic [32:0] exp32_q[$];

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=16 operation with latency, result and return-to-idle checks.
  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] es, input logic ec);
    int lat;
    chk({tag, "_in_ready"}, b16.in_ready, 1'b1);
    b16.in_a = a;
    b16.in_b = b;
    b16.in_valid = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    b16.in_a = 16'($urandom);
    b16.in_b = 16'($urandom);
    lat = 1;
    while (!b16.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_sum"}, b16.out_sum, es);
    chk({tag, "_cout"}, b16.out_cout, ec);
    b16.out_ready = 1'b1;
    tick();
    b16.out_ready = 1'b0;
    chk({tag, "_idle_ready"}, b16.in_ready, 1'b1);
    chk({tag, "_idle_valid"}, b16.out_valid, 1'b0);
  endtask

  task automatic rand16(input int n);
    logic [15:0] a, b;
    logic [16:0] e;
    logic done;
    int guard;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      exp16_q.push_back({1'b0, a} + {1'b0, b});
      guard = 0;
      while (!b16.in_ready && guard < 50) begin
        tick();
        guard++;
      end
      b16.in_a = a;
      b16.in_b = b;
      b16.in_valid = 1'b1;
      tick();
      b16.in_valid = 1'b0;
      done = 1'b0;
      guard = 0;
      while (!done && guard < 200) begin
        b16.out_ready = 1'($urandom_range(0, 1));
        if (b16.out_valid && b16.out_ready) begin
          e = exp16_q.pop_front();
          chk("rand16_result", {b16.out_cout, b16.out_sum}, e);
          done = 1'b1;
        end
        tick();
        guard++;
      end
      b16.out_ready = 1'b0;
      chk("rand16_completed", done, 1'b1);
    end
  endtask

  task automatic rand32(input int n);
    logic [31:0] a, b;
    logic [32:0] e;
    logic done;
    int guard;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      b = $urandom;
      exp32_q.push_back({1'b0, a} + {1'b0, b});
      guard = 0;
      while (!b32.in_ready && guard < 50) begin
        tick();
        guard++;
      end
      b32.in_a = a;
      b32.in_b = b;
      b32.in_valid = 1'b1;
      tick();
      b32.in_valid = 1'b0;
      done = 1'b0;
      guard = 0;
      while (!done && guard < 200) begin
        b32.out_ready = 1'($urandom_range(0, 1));
        if (b32.out_valid && b32.out_ready) begin
          e = exp32_q.pop_front();
          chk("rand32_result", {b32.out_cout, b32.out_sum}, e);
          done = 1'b1;
        end
        tick();
        guard++;
      end
      b32.out_ready = 1'b0;
      chk("rand32_completed", done, 1'b1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    logic seen;

    b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.out_ready = 1'b0;
    b4.in_valid  = 1'b0; b4.in_a  = '0; b4.in_b  = '0; b4.out_ready  = 1'b0;
    b32.in_valid = 1'b0; b32.in_a = '0; b32.in_b = '0; b32.out_ready = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_state", st16, ST_IDLE);
    chk("rst_in_ready", b16.in_ready, 1'b1);
    chk("rst_out_valid", b16.out_valid, 1'b0);
    chk("rst_sum", b16.out_sum, 16'h0000);
    chk("rst_cout", b16.out_cout, 1'b0);

    // Basic add, no carry
    op16("t1", 16'h1234, 16'h4321, 16'h5555, 1'b0);
    // Carry rippling through every nibble
    op16("t2", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    // Top-bit overflow, then zero add proves carry register is cleared
    op16("t3a", 16'h8000, 16'h8000, 16'h0000, 1'b1);
    op16("t3b", 16'h0000, 16'h0000, 16'h0000, 1'b0);

    // Backpressure in DONE: 0x7000 + 0x9001 = 0x1_0001
    b16.in_a = 16'h7000;
    b16.in_b = 16'h9001;
    b16.in_valid = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    repeat (4) tick();
    chk("t4_valid", b16.out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      b16.in_valid = 1'b1;
      b16.in_a = 16'($urandom);
      b16.in_b = 16'($urandom);
      tick();
      chk("t4_hold_valid", b16.out_valid, 1'b1);
      chk("t4_hold_sum", b16.out_sum, 16'h0001);
      chk("t4_hold_cout", b16.out_cout, 1'b1);
      chk("t4_hold_in_ready", b16.in_ready, 1'b0);
    end
    b16.in_valid = 1'b0;
    b16.out_ready = 1'b1;
    tick();
    b16.out_ready = 1'b0;
    chk("t4_idle_state", st16, ST_IDLE);
    chk("t4_idle_in_ready", b16.in_ready, 1'b1);
    chk("t4_idle_out_valid", b16.out_valid, 1'b0);
    chk("t4_idle_sum_held", b16.out_sum, 16'h0001);
    tick();
    chk("t4_no_phantom_op", st16, ST_IDLE);

    // Reset on the second ADD cycle aborts the operation
    b16.in_a = 16'h1111;
    b16.in_b = 16'h2222;
    b16.in_valid = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    tick();
    chk("t5_in_add", st16, ST_ADD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_state", st16, ST_IDLE);
    chk("t5_in_ready", b16.in_ready, 1'b1);
    chk("t5_out_valid", b16.out_valid, 1'b0);
    chk("t5_sum", b16.out_sum, 16'h0000);
    chk("t5_cout", b16.out_cout, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b16.out_valid) seen = 1'b1;
    end
    chk("t5_no_valid_after_abort", seen, 1'b0);
    op16("t5_next", 16'h0F0F, 16'h00F1, 16'h1000, 1'b0);

    // WIDTH=4 instance
    chk("w4_in_ready", b4.in_ready, 1'b1);
    b4.in_a = 4'hF;
    b4.in_b = 4'h1;
    b4.in_valid = 1'b1;
    tick();
    b4.in_valid = 1'b0;
    lat = 1;
    while (!b4.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("w4_latency", lat, 2);
    chk("w4_sum", b4.out_sum, 4'h0);
    chk("w4_cout", b4.out_cout, 1'b1);
    b4.out_ready = 1'b1;
    tick();
    b4.out_ready = 1'b0;
    chk("w4_idle_ready", b4.in_ready, 1'b1);

    // Random back-to-back operations with random result backpressure
    rand16(500);
    rand32(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
